// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive control FSM: start detect, oversample/bit counters, checker enables
//
// Ports:
//   CLK, RST          oversample clock (one tick per 1/PRESCALE bit), synchronous active-high reset
//   rx_in             raw serial line, idle high
//   par_en            parity bit present; latched when a frame starts
//   strt_glitch       registered start-check result (seen in the first DATA cycle)
//   par_err           registered parity-check result (seen in the first STOP cycle)
//   stp_err           registered stop-check result (seen in ERR_CHK)
//   edge_cnt          tick index within the current bit
//   bit_cnt           data-bit index
//   dat_samp_en       sampler enable
//   strt_chk_en, par_chk_en, stp_chk_en   checker enables
//   deser_en          deserializer shift strobe, last tick of each data bit
//   data_valid        one-cycle pulse when a frame completes without error

module uart_rx_fsm #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        ERR_CHK
    } state_t;

    localparam logic [5:0] EDGE_LAST = 6'(PRESCALE - 1);
    localparam logic [3:0] BIT_LAST  = 4'(DATA_WIDTH - 1);

    state_t     state;
    logic       par_en_lat;
    logic       par_flag;
    logic       edge_wrap;
    logic [5:0] edge_next;

    assign edge_wrap = (edge_cnt == EDGE_LAST);
    assign edge_next = edge_wrap ? 6'd0 : edge_cnt + 6'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= 6'd0;
            bit_cnt    <= 4'd0;
            par_en_lat <= 1'b0;
            par_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt  <= 4'd0;
                    edge_cnt <= 6'd0;
                    // The detect cycle is tick 0 of the start bit.
                    if (!rx_in) begin
                        state      <= START;
                        edge_cnt   <= 6'd1;
                        par_en_lat <= par_en;
                    end
                end
                START: begin
                    edge_cnt <= edge_next;
                    if (edge_wrap) begin
                        state   <= DATA;
                        bit_cnt <= 4'd0;
                    end
                end
                DATA: begin
                    // The start checker's verdict lands in the first DATA cycle.
                    if (bit_cnt == 4'd0 && edge_cnt == 6'd0 && strt_glitch) begin
                        state    <= IDLE;
                        edge_cnt <= 6'd0;
                        bit_cnt  <= 4'd0;
                    end else begin
                        edge_cnt <= edge_next;
                        if (edge_wrap) begin
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= 4'd0;
                                state   <= par_en_lat ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                end
                PARITY: begin
                    edge_cnt <= edge_next;
                    if (edge_wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // The parity verdict is only valid in the first STOP cycle;
                    // the checker clears it once its enable drops.
                    if (edge_cnt == 6'd0) begin
                        par_flag <= par_en_lat & par_err;
                    end
                    edge_cnt <= edge_next;
                    if (edge_wrap) begin
                        state <= ERR_CHK;
                    end
                end
                ERR_CHK: begin
                    bit_cnt  <= 4'd0;
                    edge_cnt <= 6'd0;
                    // A falling edge here is the next frame's tick 0.
                    if (!rx_in) begin
                        state      <= START;
                        edge_cnt   <= 6'd1;
                        par_en_lat <= par_en;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= 6'd0;
                    bit_cnt  <= 4'd0;
                end
            endcase
        end
    end

    // Enables are pure decodes of registered state/counters: no path from rx_in.
    assign dat_samp_en = (state == START) || (state == DATA) ||
                         (state == PARITY) || (state == STOP);
    assign strt_chk_en = (state == START);
    assign par_chk_en  = (state == PARITY);
    assign stp_chk_en  = (state == STOP);
    assign deser_en    = (state == DATA) && edge_wrap;
    assign data_valid  = (state == ERR_CHK) && !stp_err && !par_flag;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard bench for uart_rx_fsm with a bit-slot reference model

module tb_uart_rx_fsm;

    localparam int P    = 8;
    localparam int N    = 8;
    localparam int MAXC = 16384;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rx_in;
    logic       par_en;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic       data_valid;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    typedef struct packed {
        int   c;
        logic is_valid;
    } ev_t;

    ev_t evq[$];

    // Expected per-cycle view: {strt, par, stp, samp}, tick index, bit index.
    logic [3:0] exp_en   [MAXC];
    logic [5:0] exp_edge [MAXC];
    logic [3:0] exp_bit  [MAXC];

    uart_rx_fsm #(.PRESCALE(P), .DATA_WIDTH(N)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .rx_in       (rx_in),
        .par_en      (par_en),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin : monitor
        ev_t e;
        if (mon_on && cyc < MAXC) begin
            checks++;
            if ({strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} !== exp_en[cyc] ||
                edge_cnt !== exp_edge[cyc] || bit_cnt !== exp_bit[cyc]) begin
                errors++;
                $display("FAIL ctrl c=%0d en(strt,par,stp,samp)=%b req=%b edge=%0d req=%0d bit=%0d req=%0d",
                         cyc, {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en}, exp_en[cyc],
                         edge_cnt, exp_edge[cyc], bit_cnt, exp_bit[cyc]);
            end
            while (evq.size() > 0 && evq[0].c < cyc) begin
                e = evq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event c=%0d req_cycle=%0d req_kind=%s", cyc, e.c,
                         e.is_valid ? "data_valid" : "deser_en");
            end
            if (deser_en || data_valid) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event c=%0d deser_en=%b data_valid=%b", cyc, deser_en, data_valid);
                end else begin
                    e = evq.pop_front();
                    if (e.c != cyc || e.is_valid !== data_valid || (deser_en && data_valid)) begin
                        errors++;
                        $display("FAIL event c=%0d deser_en=%b data_valid=%b req_cycle=%0d req_kind=%s",
                                 cyc, deser_en, data_valid, e.c, e.is_valid ? "data_valid" : "deser_en");
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in       = 1'b1;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        repeat (n) tick();
    endtask

    task automatic put(input int c, input logic [3:0] en, input int ed, input int bt);
        if (c < MAXC) begin
            exp_en[c]   = en;
            exp_edge[c] = 6'(ed);
            exp_bit[c]  = 4'(bt);
        end
    endtask

    task automatic push_ev(input int c, input logic v);
        ev_t e;
        e.c        = c;
        e.is_valid = v;
        evq.push_back(e);
    endtask

    // One frame from its detect cycle. The frame is laid out as bit slots of P
    // ticks: start, N data bits, optional parity, stop; ERR_CHK is tick L.
    task automatic run_frame(input bit par, input bit perr, input bit serr,
                             input bit glitch, input bit b2b, input int rst_at);
        int         c0;
        int         L;
        int         pi;
        int         last;
        int         slot;
        logic [7:0] data;
        logic       pbit;
        c0   = cyc;
        pi   = par ? 1 : 0;
        L    = (N + 2 + pi) * P;
        data = 8'($urandom);
        pbit = ^data;

        if (glitch) begin
            for (int t = 1; t < P; t++) put(c0 + t, 4'b1001, t, 0);
            put(c0 + P, 4'b0001, 0, 0);
        end else begin
            for (int t = 1; t < L; t++) begin
                slot = t / P;
                if (slot == 0)                 put(c0 + t, 4'b1001, t % P, 0);
                else if (slot <= N)            put(c0 + t, 4'b0001, t % P, slot - 1);
                else if (par && slot == N + 1) put(c0 + t, 4'b0101, t % P, 0);
                else                           put(c0 + t, 4'b0011, t % P, 0);
            end
            for (int k = 0; k < N; k++) push_ev(c0 + (k + 2) * P - 1, 1'b0);
            if (!serr && !(par && perr)) push_ev(c0 + L, 1'b1);
        end

        last = glitch ? P : L - 1;
        for (int t = 0; t <= last; t++) begin
            if (rst_at != 0 && t == rst_at) begin
                // Reset sampled at the end of this cycle: idle from the next one.
                for (int c = c0 + t + 1; c <= c0 + L; c++) put(c, 4'b0000, 0, 0);
                while (evq.size() > 0 && evq[$].c > c0 + t) void'(evq.pop_back());
                RST         = 1'b1;
                rx_in       = 1'b1;
                strt_glitch = 1'b0;
                par_err     = 1'b0;
                stp_err     = 1'b0;
                tick();
                tick();
                RST = 1'b0;
                return;
            end
            if (glitch)                          rx_in = (t < 2) ? 1'b0 : 1'b1;
            else if (t < P)                      rx_in = 1'b0;
            else if (t < (N + 1) * P)            rx_in = data[t / P - 1];
            else if (par && t < (N + 2) * P)     rx_in = pbit;
            else                                 rx_in = 1'b1;
            par_en      = (t == 0) ? par : 1'($urandom_range(0, 1));
            strt_glitch = glitch && (t == P);
            par_err     = !glitch && perr && (t == (N + 1 + pi) * P);
            if (t >= 1) stp_err = 1'b0;
            tick();
        end

        if (glitch) begin
            rx_in       = 1'b1;
            strt_glitch = 1'b0;
            return;
        end
        stp_err = serr;
        par_err = 1'b0;
        rx_in   = b2b ? 1'b0 : 1'b1;
        if (!b2b) begin
            tick();
            stp_err = 1'b0;
        end
    endtask

    initial begin
        bit par;
        bit perr;
        bit serr;
        bit glitch;
        bit b2b;
        int rst_at;
        RST         = 1'b1;
        rx_in       = 1'b1;
        par_en      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            exp_en[i]   = 4'b0000;
            exp_edge[i] = 6'd0;
            exp_bit[i]  = 4'd0;
        end
        tick();
        tick();
        mon_on = 1'b1;
        rx_in  = 1'b0;
        tick();
        tick();
        checks++;
        if ({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid} !== 16'd0) begin
            errors++;
            $display("FAIL reset_state edge=%0d bit=%0d samp=%b strt=%b par=%b stp=%b deser=%b valid=%b req=all zero",
                     edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid);
        end
        RST = 1'b0;
        idle(3);

        run_frame(0, 0, 0, 0, 0, 0);  idle(2);   // clean 8N1
        run_frame(1, 1, 0, 0, 0, 0);  idle(1);   // parity error
        run_frame(1, 0, 0, 0, 0, 0);  idle(1);   // clean with parity
        run_frame(0, 1, 0, 0, 0, 0);  idle(1);   // par_err ignored when parity off
        run_frame(0, 0, 0, 1, 0, 0);             // start glitch, re-detect immediately
        run_frame(0, 0, 1, 0, 0, 0);  idle(1);   // stop error
        run_frame(0, 0, 0, 0, 1, 0);             // back-to-back chain
        run_frame(0, 0, 0, 0, 1, 0);
        run_frame(1, 0, 0, 0, 0, 0);  idle(2);
        run_frame(0, 0, 0, 0, 0, 30); idle(2);   // reset mid-DATA

        b2b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            par    = 1'($urandom_range(0, 1));
            perr   = ($urandom_range(0, 3) == 0);
            serr   = ($urandom_range(0, 3) == 0);
            glitch = !b2b && ($urandom_range(0, 7) == 0);
            rst_at = (!glitch && $urandom_range(0, 11) == 0) ? int'($urandom_range(1, 70)) : 0;
            b2b    = !glitch && rst_at == 0 && i != 59 && ($urandom_range(0, 2) == 0);
            run_frame(par, perr, serr, glitch, b2b, rst_at);
            if (!b2b) idle(int'($urandom_range(0, 4)));
        end
        idle(4);

        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL pending_events left=%0d req=0", evq.size());
        end
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side control FSM for the UART RX path. It detects the start-bit falling edge on the serial line and runs the oversampling edge counter and bit counter. It sequences the enables for the sampler, start/parity/stop checkers and deserializer, and issues a one-cycle `data_valid` when a frame completes without error. It sits upstream of the stop checker: it generates `stp_chk_en` and `edge_cnt` for that block and consumes its registered `stp_err`.

## Interface

- `PRESCALE`, 8: oversampling ticks per bit. Legal values: 8, 16, 32.
- `DATA_WIDTH`, 8: data bits per frame. Legal range: 5–8.

- `CLK`  in  1  oversample clock, one tick per 1/PRESCALE bit
- `RST`  in  1  synchronous, active-high reset
- `rx_in`  in  1  raw serial line, idle high
- `par_en`  in  1  parity bit present in frame
- `strt_glitch`  in  1  registered start-check result
- `par_err`  in  1  registered parity-check result
- `stp_err`  in  1  registered stop-check result
- `edge_cnt`  out  6  tick index within current bit
- `bit_cnt`  out  4  data-bit index
- `dat_samp_en`  out  1  sampler enable
- `strt_chk_en`  out  1  start-check enable
- `par_chk_en`  out  1  parity-check enable
- `stp_chk_en`  out  1  stop-check enable
- `deser_en`  out  1  deserializer shift strobe
- `data_valid`  out  1  frame accepted, one-cycle pulse

## Operation

- **Checker convention.** Each checker registers its result at `edge_cnt==PRESCALE-1` while its enable is high, and clears when its enable is low. The result is therefore visible in the first cycle after the bit ends.
- **States:** IDLE, START, DATA, PARITY, STOP, ERR_CHK.
- **IDLE**
  - `edge_cnt` = 0, `bit_cnt` = 0.
  - `rx_in==0` → START, next `edge_cnt` = 1. The detect cycle counts as tick 0.
  - `par_en` is latched on this transition and held for the whole frame.
- **Edge counter (START/DATA/PARITY/STOP)**
  - Increments each cycle.
  - At `PRESCALE-1` it wraps to 0; the wrap marks the bit boundary.
- **START**
  - `strt_chk_en` = 1.
  - At wrap → DATA, `bit_cnt` = 0.
- **DATA**
  - In the first cycle (`bit_cnt==0`, `edge_cnt==0`): if `strt_glitch==1` → IDLE immediately, counters cleared, no `deser_en` for the frame.
  - `deser_en` = 1 when `edge_cnt==PRESCALE-1`.
  - At wrap, `bit_cnt` increments.
  - At wrap with `bit_cnt==DATA_WIDTH-1` → PARITY if latched `par_en`, else STOP. `bit_cnt` returns to 0.
- **PARITY**
  - `par_chk_en` = 1.
  - At wrap → STOP.
- **STOP**
  - `stp_chk_en` = 1.
  - First cycle: `par_err` is captured into an internal flag. If parity is disabled, the flag is captured as 0.
  - At wrap → ERR_CHK.
- **ERR_CHK** (single cycle)
  - `stp_chk_en` = 0; `stp_err` still shows the registered result.
  - `data_valid` = 1 iff `stp_err==0` and the captured parity flag is 0.
  - `rx_in==0` → START with `edge_cnt` = 1 (back-to-back frame, par_en re-latched). Otherwise → IDLE.
- **Sampler enable:** `dat_samp_en` = 1 in START, DATA, PARITY and STOP.
- **Output decoding:** all enables and `data_valid` are decoded from registered state and counters. They are glitch-free and have no combinational path from `rx_in`.
- **Reset:** `RST` mid-frame overrides everything → IDLE at the next edge. `edge_cnt`, `bit_cnt`, all enables, `data_valid` and the internal parity flag are all 0.

## Timing

- All outputs are 0 during and after reset until a falling edge is detected.
- With the detect cycle at t0 and P = PRESCALE, N = DATA_WIDTH:
  - START occupies t1..t(P-1).
  - DATA bit k occupies t((k+1)P)..t((k+2)P-1).
  - `deser_en` pulses at t((k+2)P-1).
- `data_valid` timing:
  - No parity: t((N+2)P). For 8N1 with P=8 this is t80.
  - With parity: t((N+3)P). For P=8 this is t88.
- Frame period is exactly (N+2)P or (N+3)P cycles. Back-to-back frames lose no tick.
- Start-glitch abort: IDLE at t(P+1). A new falling edge is accepted from that cycle.
- An error-aborted frame returns to IDLE the cycle after ERR_CHK, unless `rx_in==0` in ERR_CHK.

## Test plan

- **Reset mid-DATA.** Assert `RST` for 2 cycles at t30. Required: all outputs 0 from the following edge, `edge_cnt`=0, and no `data_valid` for the aborted frame.
- **8N1 frame, no errors.** P=8, `par_en`=0, frame 0xA5, checker inputs held 0. Required: `deser_en` pulses exactly at t15, t23, …, t71 (8 pulses), `stp_chk_en` high t72–t79, one `data_valid` pulse at t80, then IDLE.
- **Parity error.** `par_en`=1, bench drives `par_err`=1 at t80 (first STOP cycle). Required: `par_chk_en` high t72–t79, no `data_valid` at t88, IDLE at t89. A separate run toggles `par_en` to 0 at t40: the frame must still include PARITY.
- **Start glitch.** `rx_in` low for 2 cycles, `strt_glitch`=1 at t8. Required: IDLE at t9, zero `deser_en` pulses, no `data_valid`.
- **Stop error.** `stp_err`=1 at t80. Required: `data_valid` stays 0 and IDLE at t81.
- **Back-to-back frames.** `rx_in`=0 in the ERR_CHK cycle t80. Required: START at t81 with `edge_cnt`=1, and the second `data_valid` exactly 80 cycles after the first.
